uart_rx_led: RTL and testbench

- UART receiver, 8N1 format (1 start bit, 8 data bits LSB first, 1 stop bit).
- Converts the serial `rx_uart` line into a byte and presents the last correctly framed byte on 8 LED outputs.
- Sits at the board I/O edge, between the serial pin and the LED bank.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_led_if.sv | 19 +
 rtl/uart_rx_sync.sv | 40 ++++
 rtl/uart_rx_led.sv | 133 +++++++++++++
 tb/tb_uart_rx_led.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_rx_led receiver.
//   DATA_BITS     - payload bits per frame (8N1)
//   CLKS_PER_BIT  - default bit period in clk cycles (50 MHz / 9600 baud)
//   state_e       - receiver FSM states
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_rx_led_if.sv
// ---------------------------------------------------------------------------
// uart_rx_led_if
// Board-edge signals of the receiver.
//   rx_uart - serial line into the receiver (idles high)
//   led     - last correctly framed byte, led[i] = data bit i
// Modports:
//   master - the side driving the serial line and observing the LEDs
//   slave  - the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_led_if;
  import uart_pkg::*;

  logic                 rx_uart;
  logic [DATA_BITS-1:0] led;

  modport master (output rx_uart, input led);
  modport slave  (input rx_uart, output led);

endinterface

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial input plus a falling
// edge detector on the synchronized level.
//   clk      - system clock
//   rst      - synchronous active-high reset (flops go to idle level 1)
//   rx_i     - asynchronous serial input
//   rx_s_o   - synchronized line level
//   fall_o   - one-cycle pulse when rx_s_o goes 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle (high) level so leaving reset never looks like a
  // start-bit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_led.sv
// ---------------------------------------------------------------------------
// uart_rx_led
// 8N1 UART receiver that shows the last correctly framed byte on 8 LEDs.
// Parameter:
//   T   - clk cycles per bit (>= 4); bits are sampled at cnt == T/2
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset (led = 0, FSM idle)
//   bus - uart_rx_led_if.slave: rx_uart in, led out
// ---------------------------------------------------------------------------
module uart_rx_led
  import uart_pkg::*;
#(
  parameter int T = CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_led_if.slave  bus
);

  localparam int CW = $clog2(T);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  localparam logic [CW-1:0] CNT_MID  = CW'(T / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(T - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (bus.rx_uart),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  logic [1:0]           state_q,   state_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] led_q,     led_d;

  logic cnt_wrap;
  logic cnt_mid;
  logic [CW-1:0] cnt_inc;

  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign cnt_mid  = (cnt_q == CNT_MID);
  assign cnt_inc  = cnt_wrap ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    led_d     = led_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        cnt_d = cnt_inc;
        // Line back high at mid start bit: a glitch, not a frame.
        if (cnt_mid && rx_s) begin
          state_d = ST_IDLE;
        end else if (cnt_wrap) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        cnt_d = cnt_inc;
        if (cnt_mid) begin
          shift_d[bit_idx_q] = rx_s;
        end
        if (cnt_wrap) begin
          if (bit_idx_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        cnt_d = cnt_inc;
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        // A low stop bit is a framing error: drop the byte, and since IDLE
        // waits for a falling edge the line must go high again first.
        if (cnt_mid) begin
          if (rx_s) begin
            led_d = shift_q;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      led_q     <= led_d;
    end
  end

  assign bus.led = led_q;

endmodule

// File: tb/tb_uart_rx_led.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_led
// Self-checking bench for uart_rx_led with T = 4. Frames come from a vector
// table; every expected LED value is queued when its frame is driven and
// popped when the LEDs change. Corner cases (reset, false start, reset in
// mid-frame, output latency) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_rx_led;
  import uart_pkg::*;

  localparam int T      = 4;
  localparam int PERIOD = 10;
  // Edges from the first clk edge that sees the start bit on the pin to the
  // edge that updates led.
  localparam int LAT_EDGES = 2 + 9 * T + T / 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_led_if bus ();

  uart_rx_led #(.T(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #(PERIOD / 2) clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_led;
  logic [7:0] exp_v;
  time        lat_ts = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard: every LED change outside reset must match the next queued
  // byte; a change with nothing queued is an error.
  always @(negedge clk) begin
    if (rst) begin
      prev_led = bus.led;
    end else if (bus.led !== prev_led) begin
      if (exp_q.size() == 0) begin
        check("unexpected_led_change", {24'd0, bus.led}, {24'd0, prev_led});
      end else begin
        exp_v = exp_q.pop_front();
        $display("led update: %02h (expected %02h)", bus.led, exp_v);
        check("led_update", {24'd0, bus.led}, {24'd0, exp_v});
        if (lat_ts != 0) begin
          // lat_ts is 1 time unit after the edge preceding the start bit.
          check("latency", 32'($time - PERIOD / 2),
                32'(lat_ts - 1 + PERIOD + PERIOD * LAT_EDGES));
          lat_ts = 0;
        end
      end
      prev_led = bus.led;
    end
  end

  task automatic drive_bit(input logic v);
    bus.rx_uart = v;
    repeat (T) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    bus.rx_uart = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  initial begin
    vecs[0] = '{data: 8'h3A, stop: 1'b1, exp_led: 8'h3A};
    vecs[1] = '{data: 8'h23, stop: 1'b1, exp_led: 8'h23};
    vecs[2] = '{data: 8'hFF, stop: 1'b0, exp_led: 8'h23};  // framing error
    vecs[3] = '{data: 8'h55, stop: 1'b1, exp_led: 8'h55};

    // Reset held for 3 cycles with the line idle.
    bus.rx_uart = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_led", {24'd0, bus.led}, 32'h00);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_led", {24'd0, bus.led}, 32'h00);
    check("post_reset_state", {30'd0, dut.state_q}, 32'(IDLE));
    $display("reset: led=%02h", bus.led);
    idle_bits(1);

    // Table-driven frames, 8 idle bit-times between frames.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle_bits(8);
      $display("frame %0d: data=%02h stop=%0b led=%02h", i, vecs[i].data,
               vecs[i].stop, bus.led);
      check("frame_led", {24'd0, bus.led}, {24'd0, vecs[i].exp_led});
      check("frame_queue_drained", 32'(exp_q.size()), 32'd0);
    end

    // False start: one clock low, then high again.
    bus.rx_uart = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_uart = 1'b1;
    idle_bits(3);
    $display("false start: led=%02h", bus.led);
    check("false_start_led", {24'd0, bus.led}, 32'h55);
    check("false_start_state", {30'd0, dut.state_q}, 32'(IDLE));

    // Reset during data bit 3 of an 8'hA5 frame.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    bus.rx_uart = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.rx_uart = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("midframe_reset_led", {24'd0, bus.led}, 32'h00);
    check("midframe_reset_state", {30'd0, dut.state_q}, 32'(IDLE));
    rst = 1'b0;
    idle_bits(8);
    $display("mid-frame reset: led=%02h", bus.led);
    check("after_reset_idle_led", {24'd0, bus.led}, 32'h00);

    // Full frame after the reset, with exact output latency checked.
    exp_q.push_back(8'hA5);
    lat_ts = $time;
    send_frame(8'hA5, 1'b1);
    idle_bits(8);
    $display("frame after reset: led=%02h", bus.led);
    check("a5_led", {24'd0, bus.led}, 32'hA5);
    check("a5_queue_drained", 32'(exp_q.size()), 32'd0);
    check("latency_checked", 32'(lat_ts), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
